// File: rtl/msg_calc_frame_pkg.sv
// Shared types and default widths for the framed calculator (calc_pkg).
package calc_pkg;

  localparam int unsigned CALC_DATA_W = 32;
  localparam int unsigned CALC_ID_W   = 13;
  localparam int unsigned CALC_LEN_W  = 6;

  typedef enum logic [1:0] {
    SET = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2,
    MUL = 2'd3
  } op_t;

  typedef enum logic {
    ST_IDLE,
    ST_ARGS
  } state_t;

endpackage

// File: rtl/msg_calc_frame_alu.sv
// calc_alu: combinational accumulator step (acc op data) with overflow flag.
module calc_alu
  import calc_pkg::*;
#(
  parameter int unsigned DATA_W = CALC_DATA_W
) (
  input  op_t               op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] res,
  output logic              ovf
);

  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] prod;

  assign sum  = {1'b0, acc} + {1'b0, data};
  assign prod = {{DATA_W{1'b0}}, acc} * {{DATA_W{1'b0}}, data};

  // Select the result and the op-specific overflow condition
  always_comb begin
    res = data;
    ovf = 1'b0;
    case (op)
      SET: begin
        res = data;
        ovf = 1'b0;
      end
      ADD: begin
        res = sum[DATA_W-1:0];
        ovf = sum[DATA_W];
      end
      SUB: begin
        res = acc - data;
        ovf = (data > acc);
      end
      MUL: begin
        res = prod[DATA_W-1:0];
        ovf = |prod[2*DATA_W-1:DATA_W];
      end
      default: begin
        res = data;
        ovf = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/msg_calc_frame.sv
// msg_calc_frame: header/argument framed calculator with a one-entry result
// register and a one-entry queue for a zero-length frame that aborts another.
// Optional feature macro: MSG_CALC_OVF_EN adds the out_ovf output.
module msg_calc_frame
  import calc_pkg::*;
#(
  parameter int unsigned DATA_W = CALC_DATA_W,
  parameter int unsigned ID_W   = CALC_ID_W,
  parameter int unsigned LEN_W  = CALC_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_hdr,
  input  logic [ID_W-1:0]   in_id,
  input  logic [LEN_W-1:0]  in_len,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic [ID_W-1:0]   out_id,
  output logic              out_err,
  output logic [15:0]       drop_cnt
`ifdef MSG_CALC_OVF_EN
  ,
  output logic              out_ovf
`endif
);

  state_t            state;
  logic [ID_W-1:0]   cur_id;
  logic [LEN_W-1:0]  rem;
  logic [DATA_W-1:0] acc;
  logic              first;
  logic              pend;
  logic [ID_W-1:0]   pend_id;
  logic              accept;
  op_t               alu_op;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;

  // The first argument of every frame loads the accumulator
  assign alu_op   = first ? SET : op_t'(in_op);
  assign in_ready = !rst && !pend && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  calc_alu #(.DATA_W(DATA_W)) u_alu (
    .op   (alu_op),
    .acc  (acc),
    .data (in_data),
    .res  (alu_res),
    .ovf  (alu_ovf)
  );

`ifdef MSG_CALC_OVF_EN
  logic ovf_acc;
  logic ovf_q;

  assign out_ovf = out_valid && ovf_q;

  // Sticky per-frame overflow, snapshotted alongside each presented result
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_acc <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (out_valid && out_ready && pend) begin
        ovf_q <= 1'b0;
      end
      if (accept) begin
        if (in_hdr) begin
          ovf_q   <= (state == ST_ARGS) ? ovf_acc : 1'b0;
          ovf_acc <= 1'b0;
        end else if (state == ST_ARGS) begin
          ovf_acc <= ovf_acc | alu_ovf;
          if (rem == LEN_W'(1)) begin
            ovf_q <= ovf_acc | alu_ovf;
          end
        end
      end
    end
  end
`else
  logic alu_ovf_unused;
  assign alu_ovf_unused = alu_ovf;
`endif

  // Frame FSM, accumulator, result register and drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur_id    <= '0;
      rem       <= '0;
      acc       <= '0;
      first     <= 1'b0;
      pend      <= 1'b0;
      pend_id   <= '0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_id    <= '0;
      out_err   <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      // A consumed result is either retired or replaced by the queued
      // zero-length result; accept is blocked while that queue is full,
      // so the two paths below never present in the same cycle.
      if (out_valid && out_ready) begin
        if (pend) begin
          out_valid <= 1'b1;
          out_res   <= '0;
          out_id    <= pend_id;
          out_err   <= 1'b0;
          pend      <= 1'b0;
        end else begin
          out_valid <= 1'b0;
        end
      end
      if (accept) begin
        if (in_hdr) begin
          if (state == ST_ARGS) begin
            out_valid <= 1'b1;
            out_res   <= acc;
            out_id    <= cur_id;
            out_err   <= 1'b1;
            if (in_len == '0) begin
              pend    <= 1'b1;
              pend_id <= in_id;
            end
          end else if (in_len == '0) begin
            out_valid <= 1'b1;
            out_res   <= '0;
            out_id    <= in_id;
            out_err   <= 1'b0;
          end
          cur_id <= in_id;
          rem    <= in_len;
          acc    <= '0;
          first  <= 1'b1;
          state  <= (in_len != '0) ? ST_ARGS : ST_IDLE;
        end else if (state == ST_IDLE) begin
          if (drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
          end
        end else begin
          acc   <= alu_res;
          first <= 1'b0;
          rem   <= rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            out_valid <= 1'b1;
            out_res   <= alu_res;
            out_id    <= cur_id;
            out_err   <= 1'b0;
            state     <= ST_IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_msg_calc_frame.sv
// Self-checking bench for msg_calc_frame: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_msg_calc_frame;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 13;
  localparam int unsigned LEN_W  = 6;

  typedef struct {
    logic [DATA_W-1:0] res;
    logic [ID_W-1:0]   id;
    logic              err;
  } res_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_hdr = 1'b0;
  logic [ID_W-1:0]   in_id = '0;
  logic [LEN_W-1:0]  in_len = '0;
  logic [1:0]        in_op = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_res;
  logic [ID_W-1:0]   out_id;
  logic              out_err;
  logic [15:0]       drop_cnt;
`ifdef MSG_CALC_OVF_EN
  logic              out_ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int                m_open = 0;
  int                m_rem  = 0;
  int                m_first = 0;
  logic [DATA_W-1:0] m_acc = '0;
  logic [ID_W-1:0]   m_id  = '0;
  logic              m_ov  = 1'b0;
  res_t              m_out;
  logic              m_pend = 1'b0;
  res_t              m_pr;
  logic [15:0]       m_drop = '0;

  logic last_rdy;
  logic last_exp;

  always #5 clk = ~clk;

  msg_calc_frame #(.DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_hdr    (in_hdr),
    .in_id     (in_id),
    .in_len    (in_len),
    .in_op     (in_op),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_id    (out_id),
    .out_err   (out_err),
    .drop_cnt  (drop_cnt)
`ifdef MSG_CALC_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  // Reference: process one clock edge at message level
  task automatic model_tick(input logic r, input logic v, input logic h,
                            input logic [ID_W-1:0] id, input logic [LEN_W-1:0] len,
                            input logic [1:0] op, input logic [DATA_W-1:0] d,
                            input logic ordy, input logic rdy);
    res_t nq[$];
    res_t t;
    if (r) begin
      m_open = 0; m_rem = 0; m_first = 0; m_acc = '0; m_id = '0;
      m_ov = 1'b0; m_pend = 1'b0; m_drop = '0;
      m_out = '{res: '0, id: '0, err: 1'b0};
      return;
    end
    if (v && rdy) begin
      if (h) begin
        if (m_open != 0) begin
          t = '{res: m_acc, id: m_id, err: 1'b1};
          nq.push_back(t);
        end
        m_open = (len != 0) ? 1 : 0;
        m_rem = int'(len); m_acc = '0; m_id = id; m_first = 1;
        if (len == 0) begin
          t = '{res: '0, id: id, err: 1'b0};
          nq.push_back(t);
        end
      end else if (m_open == 0) begin
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end else begin
        if (m_first != 0) m_acc = d;
        else case (op)
          2'd0: m_acc = d;
          2'd1: m_acc = m_acc + d;
          2'd2: m_acc = m_acc - d;
          default: m_acc = m_acc * d;
        endcase
        m_first = 0;
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_open = 0;
          t = '{res: m_acc, id: m_id, err: 1'b0};
          nq.push_back(t);
        end
      end
    end
    if (m_ov && ordy) begin
      m_ov = 1'b0;
      if (m_pend) begin m_ov = 1'b1; m_out = m_pr; m_pend = 1'b0; end
    end
    if (nq.size() > 0) begin m_ov = 1'b1; m_out = nq[0]; end
    if (nq.size() > 1) begin m_pend = 1'b1; m_pr = nq[1]; end
  endtask

  // Drive one cycle from a negedge, advance the model at posedge, return at next negedge
  task automatic step(input logic r, input logic v, input logic h,
                      input logic [ID_W-1:0] id, input logic [LEN_W-1:0] len,
                      input logic [1:0] op, input logic [DATA_W-1:0] d, input logic ordy);
    rst = r; in_valid = v; in_hdr = h; in_id = id; in_len = len;
    in_op = op; in_data = d; out_ready = ordy;
    #1;
    last_rdy = in_ready;
    last_exp = !r && !m_pend && (!m_ov || ordy);
    @(posedge clk);
    model_tick(r, v, h, id, len, op, d, ordy, last_exp);
    @(negedge clk);
  endtask

  task automatic hdr(input logic [ID_W-1:0] id, input logic [LEN_W-1:0] len, input logic ordy);
    step(1'b0, 1'b1, 1'b1, id, len, 2'd0, '0, ordy);
  endtask

  task automatic arg(input logic [1:0] op, input logic [DATA_W-1:0] d, input logic ordy);
    step(1'b0, 1'b1, 1'b0, '0, '0, op, d, ordy);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 1'b0, '0, '0, 2'd0, '0, ordy);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, '0, '0, 2'd0, '0, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, '0, 2'd0, '0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (last_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 0", last_rdy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_checks++; if ({out_res, out_id, out_err, drop_cnt} !== '0) begin n_fail++; $display("FAIL reset_outputs: res %0h id %0h err %0b drop %0d want all 0", out_res, out_id, out_err, drop_cnt); end
    idle(1'b1);
    n_checks++; if (last_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %0b want 1", last_rdy); end
  endtask

  task automatic test_basic();
    hdr(13'd5, 6'd3, 1'b1);
    arg(2'd0, 32'd7, 1'b1);
    arg(2'd1, 32'd3, 1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %0b want 0", out_valid); end
    arg(2'd3, 32'd4, 1'b1);
    n_checks++; if ({out_valid, out_res, out_id, out_err} !== {1'b1, 32'd40, 13'd5, 1'b0}) begin n_fail++; $display("FAIL basic_result: v %0b res %0d id %0d err %0b want 1/40/5/0", out_valid, out_res, out_id, out_err); end
    idle(1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_consumed: got %0b want 0", out_valid); end
  endtask

  task automatic test_first_set();
    hdr(13'd9, 6'd2, 1'b1);
    arg(2'd2, 32'd10, 1'b1);
    arg(2'd1, 32'd5, 1'b1);
    n_checks++; if ({out_valid, out_res, out_id, out_err} !== {1'b1, 32'd15, 13'd9, 1'b0}) begin n_fail++; $display("FAIL first_set: v %0b res %0d id %0d err %0b want 1/15/9/0", out_valid, out_res, out_id, out_err); end
    idle(1'b1);
  endtask

  task automatic test_abort_back_to_back();
    hdr(13'd1, 6'd4, 1'b1);
    arg(2'd0, 32'd2, 1'b1);
    arg(2'd1, 32'd3, 1'b1);
    hdr(13'd2, 6'd1, 1'b1);
    n_checks++; if ({out_valid, out_res, out_id, out_err} !== {1'b1, 32'd5, 13'd1, 1'b1}) begin n_fail++; $display("FAIL abort_result: v %0b res %0d id %0d err %0b want 1/5/1/1", out_valid, out_res, out_id, out_err); end
    arg(2'd0, 32'd8, 1'b1);
    n_checks++; if (last_rdy !== 1'b1) begin n_fail++; $display("FAIL abort_b2b_ready: got %0b want 1", last_rdy); end
    n_checks++; if ({out_valid, out_res, out_id, out_err} !== {1'b1, 32'd8, 13'd2, 1'b0}) begin n_fail++; $display("FAIL abort_next: v %0b res %0d id %0d err %0b want 1/8/2/0", out_valid, out_res, out_id, out_err); end
    idle(1'b1);
  endtask

  task automatic test_backpressure();
    hdr(13'd3, 6'd1, 1'b0);
    arg(2'd0, 32'h55, 1'b0);
    for (int i = 0; i < 10; i++) begin
      hdr(13'd7, 6'd0, 1'b0);
      n_checks++; if (last_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_ready cycle %0d: got %0b want 0", i, last_rdy); end
      n_checks++; if ({out_valid, out_res, out_id, out_err} !== {1'b1, 32'h55, 13'd3, 1'b0}) begin n_fail++; $display("FAIL bp_hold cycle %0d: v %0b res %0h id %0d err %0b want 1/55/3/0", i, out_valid, out_res, out_id, out_err); end
    end
    hdr(13'd7, 6'd0, 1'b1);
    n_checks++; if (last_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %0b want 1", last_rdy); end
    n_checks++; if ({out_valid, out_res, out_id, out_err} !== {1'b1, 32'd0, 13'd7, 1'b0}) begin n_fail++; $display("FAIL bp_zero_len: v %0b res %0h id %0d err %0b want 1/0/7/0", out_valid, out_res, out_id, out_err); end
    idle(1'b1);
  endtask

  task automatic test_zero_len_abort();
    hdr(13'd4, 6'd2, 1'b1);
    arg(2'd0, 32'd9, 1'b1);
    hdr(13'd6, 6'd0, 1'b0);
    n_checks++; if ({out_valid, out_res, out_id, out_err} !== {1'b1, 32'd9, 13'd4, 1'b1}) begin n_fail++; $display("FAIL zl_abort: v %0b res %0d id %0d err %0b want 1/9/4/1", out_valid, out_res, out_id, out_err); end
    idle(1'b1);
    n_checks++; if (last_rdy !== 1'b0) begin n_fail++; $display("FAIL zl_pend_ready: got %0b want 0", last_rdy); end
    n_checks++; if ({out_valid, out_res, out_id, out_err} !== {1'b1, 32'd0, 13'd6, 1'b0}) begin n_fail++; $display("FAIL zl_follow: v %0b res %0d id %0d err %0b want 1/0/6/0", out_valid, out_res, out_id, out_err); end
    idle(1'b1);
    n_checks++; if ({last_rdy, out_valid} !== 2'b10) begin n_fail++; $display("FAIL zl_drain: ready %0b valid %0b want 1/0", last_rdy, out_valid); end
  endtask

  task automatic test_drop_and_reset();
    do_reset();
    for (int i = 0; i < 3; i++) arg(2'd1, 32'd1, 1'b1);
    n_checks++; if ({drop_cnt, out_valid} !== {16'd3, 1'b0}) begin n_fail++; $display("FAIL drop_cnt: cnt %0d valid %0b want 3/0", drop_cnt, out_valid); end
    hdr(13'd8, 6'd3, 1'b1);
    arg(2'd0, 32'd5, 1'b1);
    step(1'b1, 1'b1, 1'b0, '0, '0, 2'd1, 32'd6, 1'b1);
    n_checks++; if (last_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %0b want 0", last_rdy); end
    n_checks++; if ({out_valid, out_res, out_id, out_err, drop_cnt} !== '0) begin n_fail++; $display("FAIL rst_midframe: v %0b res %0h id %0h err %0b drop %0d want all 0", out_valid, out_res, out_id, out_err, drop_cnt); end
    arg(2'd1, 32'd6, 1'b1);
    n_checks++; if ({out_valid, drop_cnt} !== {1'b0, 16'd1}) begin n_fail++; $display("FAIL rst_no_result: valid %0b drop %0d want 0/1", out_valid, drop_cnt); end
  endtask

`ifdef MSG_CALC_OVF_EN
  task automatic test_ovf();
    hdr(13'd11, 6'd2, 1'b1);
    arg(2'd0, 32'hFFFF_FFFF, 1'b1);
    arg(2'd1, 32'd1, 1'b1);
    n_checks++; if ({out_valid, out_res, out_ovf} !== {1'b1, 32'd0, 1'b1}) begin n_fail++; $display("FAIL ovf_add: v %0b res %0h ovf %0b want 1/0/1", out_valid, out_res, out_ovf); end
    idle(1'b1);
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_qualified: got %0b want 0", out_ovf); end
  endtask
`endif

  task automatic test_random();
    logic v, h, ordy;
    logic [LEN_W-1:0] len;
    logic [DATA_W-1:0] d;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      v    = ($urandom_range(0, 9) < 7);
      h    = ($urandom_range(0, 9) < 3);
      ordy = ($urandom_range(0, 9) < 7);
      len  = LEN_W'($urandom_range(0, 3));
      d    = ($urandom_range(0, 3) == 0) ? $urandom : DATA_W'($urandom_range(0, 20));
      step(1'b0, v, h, ID_W'($urandom), len, 2'($urandom_range(0, 3)), d, ordy);
      n_checks++; if (last_rdy !== last_exp) begin n_fail++; $display("FAIL rnd_ready cycle %0d: got %0b want %0b", i, last_rdy, last_exp); end
      n_checks++; if (out_valid !== m_ov) begin n_fail++; $display("FAIL rnd_valid cycle %0d: got %0b want %0b", i, out_valid, m_ov); end
      if (m_ov) begin
        n_checks++; if ({out_res, out_id, out_err} !== {m_out.res, m_out.id, m_out.err}) begin n_fail++; $display("FAIL rnd_result cycle %0d: res %0h id %0h err %0b want %0h/%0h/%0b", i, out_res, out_id, out_err, m_out.res, m_out.id, m_out.err); end
      end
      n_checks++; if (drop_cnt !== m_drop) begin n_fail++; $display("FAIL rnd_drop cycle %0d: got %0d want %0d", i, drop_cnt, m_drop); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_first_set();
    test_abort_back_to_back();
    test_backpressure();
    test_zero_len_abort();
    test_drop_and_reset();
`ifdef MSG_CALC_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/msg_calc_frame.md
MSG_CALC_FRAME -- requirements
Module: msg_calc_frame

Interface
REQ-001 Parameter DATA_W, default 32, sets operand and result width in bits.
REQ-002 Parameter ID_W, default 13, sets frame id width.
REQ-003 Parameter LEN_W, default 6, sets header length field width; max args per frame is 2^LEN_W-1.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst  input  1  reset, synchronous and active-high; sampled on posedge clk.
REQ-006 in_valid  input  1  message present this cycle.
REQ-007 in_ready  output  1  block accepts message; transfer when in_valid && in_ready.
REQ-008 in_hdr  input  1  1 = header message, 0 = argument message.
REQ-009 in_id  input  ID_W  frame id; meaningful only with in_hdr=1.
REQ-010 in_len  input  LEN_W  number of argument messages that follow; meaningful only with in_hdr=1.
REQ-011 in_op  input  2  op_t (SET, ADD, SUB, MUL); meaningful only with in_hdr=0.
REQ-012 in_data  input  DATA_W  operand; meaningful only with in_hdr=0.
REQ-013 out_valid  output  1  completed-frame result held.
REQ-014 out_ready  input  1  consumer takes the result when out_valid && out_ready.
REQ-015 out_res  output  DATA_W  frame result.
REQ-016 out_id  output  ID_W  id of the completed frame.
REQ-017 out_err  output  1  frame was aborted by an early header.
REQ-018 drop_cnt  output  16  count of argument messages dropped while IDLE.

Function
REQ-019 FSM states: IDLE (no frame open) and ARGS (remaining > 0).
REQ-020 Header accepted in IDLE: latch id, set remaining=in_len, clear accumulator; go to ARGS if in_len>0.
REQ-021 Header accepted in IDLE with in_len=0: stay IDLE; present result 0, that id, out_err=0 next cycle.
REQ-022 First argument of a frame: executes as SET regardless of in_op.
REQ-023 Subsequent arguments: acc = acc op in_data, modulo 2^DATA_W, unsigned; MUL keeps the low DATA_W bits.
REQ-024 Each accepted argument in ARGS decrements remaining; last argument (remaining=1) returns to IDLE and presents the result with out_err=0.
REQ-025 Result latency: out_valid rises on the cycle after the completing message is accepted.
REQ-026 Header accepted in ARGS (abort): present the partial acc, old id, out_err=1; the new header is processed as in REQ-020/021 in the same cycle.
REQ-027 Abort by a header with in_len=0: the aborted result takes precedence; the zero-length frame result follows one cycle after the aborted result is consumed.
REQ-028 Argument accepted in IDLE: dropped; drop_cnt increments and saturates at 16'hFFFF.
REQ-029 in_ready = !out_valid || out_ready, plus deasserted while a pending zero-length result is queued (REQ-027).
REQ-030 out_res, out_id and out_err are held stable while out_valid && !out_ready.
REQ-031 A result consumed in the same cycle a new frame completes is replaced, with no bubble.

Reset
REQ-032 On rst: state=IDLE, out_valid=0, out_res=0, out_id=0, out_err=0, drop_cnt=0, accumulator=0, remaining=0.
REQ-033 rst mid-frame discards the open frame and any pending result, and emits nothing.
REQ-034 in_ready is 0 during rst and 1 on the first cycle after rst deasserts.

Configuration
REQ-035 Macro MSG_CALC_OVF_EN: when defined, adds output port out_ovf (1 bit).
REQ-036 With MSG_CALC_OVF_EN, out_ovf is set if any ADD carry-out, SUB borrow, or MUL nonzero high half occurred in the frame; it is qualified by out_valid.
REQ-037 Without MSG_CALC_OVF_EN, the port and its logic are absent; all other behaviour is identical.

Structure
REQ-038 Package calc_pkg holds op_t (SET=0, ADD=1, SUB=2, MUL=3) and the default DATA_W, ID_W and LEN_W constants.
REQ-039 Sub-module calc_alu is combinational (op, acc, data -> next acc, ovf flag) and parametrised by DATA_W.

Verification
REQ-040 Header id=5 len=3; args SET 7, ADD 3, MUL 4; out_ready=1 -> out_valid one cycle after the 3rd arg, with out_res=40, out_id=5, out_err=0.
REQ-041 Header id=9 len=2; first arg op=SUB data=10, then ADD 5 -> out_res=15 (first arg forced to SET).
REQ-042 Header id=1 len=4; args SET 2, ADD 3; then header id=2 len=1, arg SET 8 -> result (5, id 1, err 1), then result (8, id 2, err 0).
REQ-043 out_ready=0 with a result pending -> in_ready=0 and outputs stable for 10 cycles; out_ready=1 -> consumed, and in_ready=1 in the same cycle.
REQ-044 Three args in IDLE -> drop_cnt=3 and no out_valid; rst asserted mid-frame -> all outputs 0 and no result.
REQ-045 MSG_CALC_OVF_EN defined, DATA_W=32; SET 32'hFFFFFFFF then ADD 1 -> out_res=0, out_ovf=1.
